// File: rtl/fm_spy_buffer_mc.sv
// fm_spy_buffer_mc: multi-channel circular spy buffer with trigger freeze, readout and playback
module fm_spy_buffer_mc #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 10
) (
  input  logic                       clk_hs,
  input  logic                       rst_hs,
  input  logic [N_CH*DATA_W-1:0]     ch_data,
  input  logic [N_CH-1:0]            ch_valid,
  input  logic                       arm,
  input  logic                       trig,
  input  logic                       freeze_req,
  input  logic [ADDR_W-1:0]          post_trig_cnt,
  input  logic [1:0]                 pb_mode,
  input  logic                       pb_start,
  input  logic                       pb_stop,
  input  logic                       rd_en,
  input  logic [$clog2(N_CH)-1:0]    rd_ch_sel,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_sample_valid,
  output logic                       rd_valid,
  output logic [N_CH*DATA_W-1:0]     pb_data,
  output logic [N_CH-1:0]            pb_valid,
  output logic [2:0]                 state_o,
  output logic [ADDR_W-1:0]          wr_ptr_o,
  output logic [ADDR_W-1:0]          trig_ptr_o,
  output logic                       trig_seen_o,
  output logic                       wrapped_o
);
  typedef enum logic [2:0] {IDLE, CAPTURE, POST_TRIG, FROZEN, PLAYBACK} state_t;
  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};
  state_t state;
  logic [DATA_W:0] mem [N_CH][2**ADDR_W];
  logic [ADDR_W-1:0] wr_ptr, trig_ptr, cnt, pb_addr, pb_base;
  logic [ADDR_W:0] pb_cnt, pb_len;
  logic trig_seen, wrapped, pb_run, pb_loop;
  logic we, iss, rd_go, r1_v, s1_v, empty;
  logic [DATA_W:0] r1_word;
  logic [DATA_W:0] s1_word [N_CH];
  assign we = (state == CAPTURE || state == POST_TRIG) && !freeze_req;
  assign iss = state == PLAYBACK && pb_run && !pb_stop;
  assign rd_go = rd_en && (state == IDLE || state == FROZEN);
  assign empty = wr_ptr == '0 && !wrapped;
  assign state_o = state;
  assign wr_ptr_o = wr_ptr;
  assign trig_ptr_o = trig_ptr;
  assign trig_seen_o = trig_seen;
  assign wrapped_o = wrapped;
  always_ff @(posedge clk_hs)
    if (we)
      for (int i = 0; i < N_CH; i++)
        mem[i][wr_ptr] <= {ch_valid[i], ch_data[i*DATA_W +: DATA_W]};
  // two-stage read paths: RAM register, then output register
  always_ff @(posedge clk_hs or negedge rst_hs)
    if (!rst_hs) begin
      r1_v <= 1'b0;
      r1_word <= '0;
      rd_valid <= 1'b0;
      rd_data <= '0;
      rd_sample_valid <= 1'b0;
      s1_v <= 1'b0;
      pb_data <= '0;
      pb_valid <= '0;
      for (int i = 0; i < N_CH; i++) s1_word[i] <= '0;
    end else begin
      r1_v <= rd_go;
      if (rd_go) r1_word <= mem[rd_ch_sel][rd_addr];
      rd_valid <= r1_v;
      rd_data <= r1_v ? r1_word[DATA_W-1:0] : '0;
      rd_sample_valid <= r1_v && r1_word[DATA_W];
      s1_v <= iss;
      for (int i = 0; i < N_CH; i++) begin
        if (iss) s1_word[i] <= mem[i][pb_addr];
        pb_data[i*DATA_W +: DATA_W] <= s1_v ? s1_word[i][DATA_W-1:0] : '0;
        pb_valid[i] <= s1_v && s1_word[i][DATA_W];
      end
    end
  always_ff @(posedge clk_hs or negedge rst_hs)
    if (!rst_hs) begin
      state <= IDLE;
      wr_ptr <= '0;
      trig_ptr <= '0;
      cnt <= '0;
      trig_seen <= 1'b0;
      wrapped <= 1'b0;
      pb_addr <= '0;
      pb_base <= '0;
      pb_cnt <= '0;
      pb_len <= '0;
      pb_run <= 1'b0;
      pb_loop <= 1'b0;
    end else begin
      if (we) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (&wr_ptr) wrapped <= 1'b1;
      end
      case (state)
        IDLE, FROZEN:
          if (arm) begin
            state <= CAPTURE;
            wr_ptr <= '0;
            wrapped <= 1'b0;
            trig_seen <= 1'b0;
          end else if (state == FROZEN && pb_start && pb_mode != 2'd0 && !empty) begin
            state <= PLAYBACK;
            pb_run <= 1'b1;
            pb_loop <= pb_mode == 2'd2;
            pb_base <= wrapped ? wr_ptr : '0;
            pb_addr <= wrapped ? wr_ptr : '0;
            pb_len <= wrapped ? FULL : {1'b0, wr_ptr};
            pb_cnt <= wrapped ? FULL : {1'b0, wr_ptr};
          end
        CAPTURE:
          if (trig) begin
            trig_ptr <= wr_ptr;
            trig_seen <= 1'b1;
            cnt <= post_trig_cnt;
            state <= (freeze_req || post_trig_cnt == '0) ? FROZEN : POST_TRIG;
          end else if (freeze_req) state <= FROZEN;
        POST_TRIG: begin
          cnt <= cnt - 1'b1;
          if (freeze_req || cnt == ADDR_W'(1)) state <= FROZEN;
        end
        PLAYBACK:
          if (pb_stop) begin
            state <= FROZEN;
            pb_run <= 1'b0;
          end else if (pb_run) begin
            if (pb_cnt == (ADDR_W+1)'(1)) begin
              pb_run <= pb_loop;
              pb_cnt <= pb_len;
              pb_addr <= pb_base;
            end else begin
              pb_cnt <= pb_cnt - 1'b1;
              pb_addr <= pb_addr + 1'b1;
            end
          end else if (!s1_v) state <= FROZEN;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fm_spy_buffer_mc.sv
// tb_fm_spy_buffer_mc: scoreboard bench for the spy buffer with a small RAM model
module tb_fm_spy_buffer_mc;
  localparam int N_CH = 2, DATA_W = 16, ADDR_W = 4, DEPTH = 16;
  logic clk_hs = 0, rst_hs = 1;
  logic [N_CH*DATA_W-1:0] ch_data = '0;
  logic [N_CH-1:0] ch_valid = '0;
  logic arm = 0, trig = 0, freeze_req = 0, pb_start = 0, pb_stop = 0, rd_en = 0;
  logic [ADDR_W-1:0] post_trig_cnt = '0, rd_addr = '0;
  logic [1:0] pb_mode = '0;
  logic rd_ch_sel = 0;
  logic [DATA_W-1:0] rd_data;
  logic rd_sample_valid, rd_valid, trig_seen_o, wrapped_o;
  logic [N_CH*DATA_W-1:0] pb_data;
  logic [N_CH-1:0] pb_valid;
  logic [2:0] state_o;
  logic [ADDR_W-1:0] wr_ptr_o, trig_ptr_o;

  fm_spy_buffer_mc #(.N_CH(N_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_hs(clk_hs), .rst_hs(rst_hs), .ch_data(ch_data), .ch_valid(ch_valid),
    .arm(arm), .trig(trig), .freeze_req(freeze_req), .post_trig_cnt(post_trig_cnt),
    .pb_mode(pb_mode), .pb_start(pb_start), .pb_stop(pb_stop), .rd_en(rd_en),
    .rd_ch_sel(rd_ch_sel), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_sample_valid(rd_sample_valid), .rd_valid(rd_valid), .pb_data(pb_data),
    .pb_valid(pb_valid), .state_o(state_o), .wr_ptr_o(wr_ptr_o), .trig_ptr_o(trig_ptr_o),
    .trig_seen_o(trig_seen_o), .wrapped_o(wrapped_o));

  always #5 clk_hs = ~clk_hs;

  typedef struct { int due; logic [DATA_W:0] word; } rd_t;
  typedef struct { logic [N_CH*DATA_W-1:0] d; logic [N_CH-1:0] v; } pb_t;
  rd_t rq[$];
  pb_t pq[$];
  logic [DATA_W:0] mdl [N_CH][DEPTH];
  int total = 0, bad = 0, cyc = 0, pb_words = 0, mwp = 0;

  always @(posedge clk_hs) cyc <= cyc + 1;

  // output monitor: pops the scoreboards whenever the DUT presents a word
  always @(posedge clk_hs) begin
    rd_t r;
    pb_t p;
    #1;
    if (rd_valid) begin
      total++;
      if (rq.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected got=%h", {rd_sample_valid, rd_data});
      end else begin
        r = rq.pop_front();
        if ({rd_sample_valid, rd_data} !== r.word || cyc != r.due) begin
          bad++;
          $display("FAIL rd_word got=%h@%0d exp=%h@%0d", {rd_sample_valid, rd_data}, cyc, r.word, r.due);
        end
      end
    end
    if (pb_valid !== '0) begin
      total++;
      pb_words++;
      if (pq.size() == 0) begin
        bad++;
        $display("FAIL pb_unexpected got=%h/%b", pb_data, pb_valid);
      end else begin
        p = pq.pop_front();
        if (pb_data !== p.d || pb_valid !== p.v) begin
          bad++;
          $display("FAIL pb_word got=%h/%b exp=%h/%b", pb_data, pb_valid, p.d, p.v);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_hs);
    #1;
  endtask

  task automatic do_arm();
    arm = 1;
    step();
    arm = 0;
    mwp = 0;
  endtask

  task automatic cap(input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1, input logic [1:0] v);
    ch_data = {d1, d0};
    ch_valid = v;
    step();
    mdl[0][mwp] = {v[0], d0};
    mdl[1][mwp] = {v[1], d1};
    mwp = (mwp + 1) % DEPTH;
  endtask

  task automatic rd(input int ch, input int a);
    rd_en = 1;
    rd_ch_sel = ch[0];
    rd_addr = a[ADDR_W-1:0];
    rq.push_back('{due: cyc + 2, word: mdl[ch][a]});
    step();
    rd_en = 0;
  endtask

  task automatic push_pb(input int a);
    pb_t p;
    for (int c = 0; c < N_CH; c++) begin
      p.d[c*DATA_W +: DATA_W] = mdl[c][a][DATA_W-1:0];
      p.v[c] = mdl[c][a][DATA_W];
    end
    pq.push_back(p);
  endtask

  task automatic test_reset();
    #2 rst_hs = 0;
    step();
    step();
    total++;
    if ({state_o, wr_ptr_o, trig_ptr_o, trig_seen_o, wrapped_o} !== '0) begin
      bad++;
      $display("FAIL reset_status got=%0d/%0d/%0d/%b/%b", state_o, wr_ptr_o, trig_ptr_o, trig_seen_o, wrapped_o);
    end
    total++;
    if ({rd_data, rd_sample_valid, rd_valid, pb_data, pb_valid} !== '0) begin
      bad++;
      $display("FAIL reset_data got=%h/%b/%b/%h/%b", rd_data, rd_sample_valid, rd_valid, pb_data, pb_valid);
    end
    rst_hs = 1;
    step();
  endtask

  task automatic test_trigger();
    do_arm();
    total++;
    if (state_o !== 3'd1) begin bad++; $display("FAIL arm_state got=%0d exp=1", state_o); end
    for (int k = 0; k < 5; k++) begin
      rd_en = (k == 2);
      cap(DATA_W'(k), DATA_W'(16'h10 + k), k[0] ? 2'b11 : 2'b01);
    end
    rd_en = 0;
    trig = 1;
    post_trig_cnt = 3;
    cap(16'h5, 16'h15, 2'b10);
    trig = 0;
    total++;
    if ({state_o, trig_ptr_o, trig_seen_o} !== {3'd2, 4'd5, 1'b1}) begin
      bad++;
      $display("FAIL trig_capture got=%0d/%0d/%b exp=2/5/1", state_o, trig_ptr_o, trig_seen_o);
    end
    trig = 1;
    cap(16'h6, 16'h16, 2'b11);
    trig = 0;
    cap(16'h7, 16'h17, 2'b11);
    total++;
    if ({state_o, trig_ptr_o} !== {3'd2, 4'd5}) begin
      bad++;
      $display("FAIL post_trig_hold got=%0d/%0d exp=2/5", state_o, trig_ptr_o);
    end
    cap(16'h8, 16'h18, 2'b11);
    total++;
    if ({state_o, wr_ptr_o, wrapped_o} !== {3'd3, 4'd9, 1'b0}) begin
      bad++;
      $display("FAIL post_trig_end got=%0d/%0d/%b exp=3/9/0", state_o, wr_ptr_o, wrapped_o);
    end
    rd(1, 5);
    rd(0, 5);
    rd(1, 8);
    rd(0, 1);
    rd(1, 2);
    repeat (4) step();
    total++;
    if (rq.size() != 0) begin bad++; $display("FAIL trig_reads pending=%0d exp=0", rq.size()); rq.delete(); end
  endtask

  task automatic test_wrap_playback();
    do_arm();
    for (int k = 0; k < 20; k++) cap(DATA_W'(16'h100 + k), DATA_W'(16'h200 + k), 2'b11);
    freeze_req = 1;
    ch_data = {16'hdead, 16'hbeef};
    step();
    freeze_req = 0;
    total++;
    if ({state_o, wr_ptr_o, wrapped_o} !== {3'd3, 4'd4, 1'b1}) begin
      bad++;
      $display("FAIL wrap_freeze got=%0d/%0d/%b exp=3/4/1", state_o, wr_ptr_o, wrapped_o);
    end
    rd(0, 4);
    repeat (4) step();
    total++;
    if (rq.size() != 0) begin bad++; $display("FAIL wrap_read pending=%0d exp=0", rq.size()); rq.delete(); end
    pb_words = 0;
    for (int i = 0; i < 16; i++) push_pb((4 + i) % DEPTH);
    pb_mode = 1;
    pb_start = 1;
    step();
    pb_start = 0;
    pb_mode = 2;
    total++;
    if (state_o !== 3'd4) begin bad++; $display("FAIL pb_enter got=%0d exp=4", state_o); end
    for (int i = 0; i < 40 && state_o != 3'd3; i++) step();
    step();
    total++;
    if ({state_o, pb_words} !== {3'd3, 32'd16} || pq.size() != 0) begin
      bad++;
      $display("FAIL pb_single got=%0d/%0d left=%0d exp=3/16/0", state_o, pb_words, pq.size());
      pq.delete();
    end
  endtask

  task automatic test_trig_freeze();
    do_arm();
    for (int k = 0; k < 7; k++) cap(DATA_W'(16'h300 + k), DATA_W'(16'h380 + k), 2'b11);
    trig = 1;
    freeze_req = 1;
    post_trig_cnt = 4;
    ch_data = {16'hbeef, 16'hbeef};
    step();
    trig = 0;
    freeze_req = 0;
    total++;
    if ({state_o, trig_seen_o, trig_ptr_o, wr_ptr_o} !== {3'd3, 1'b1, 4'd7, 4'd7}) begin
      bad++;
      $display("FAIL trig_freeze got=%0d/%b/%0d/%0d exp=3/1/7/7", state_o, trig_seen_o, trig_ptr_o, wr_ptr_o);
    end
    rd(0, 7);
    rd(1, 6);
    repeat (4) step();
    total++;
    if (rq.size() != 0) begin bad++; $display("FAIL tf_read pending=%0d exp=0", rq.size()); rq.delete(); end
  endtask

  task automatic test_full_post();
    do_arm();
    for (int k = 0; k < 3; k++) cap(DATA_W'(16'h400 + k), DATA_W'(16'h480 + k), 2'b11);
    trig = 1;
    post_trig_cnt = 15;
    cap(16'h4aa, 16'h4bb, 2'b01);
    trig = 0;
    for (int k = 0; k < 14; k++) cap(DATA_W'(16'h410 + k), DATA_W'(16'h490 + k), 2'b11);
    total++;
    if (state_o !== 3'd2) begin bad++; $display("FAIL full_post_hold got=%0d exp=2", state_o); end
    cap(16'h4ff, 16'h4fe, 2'b11);
    total++;
    if ({state_o, wr_ptr_o, wrapped_o, trig_ptr_o} !== {3'd3, 4'd3, 1'b1, 4'd3}) begin
      bad++;
      $display("FAIL full_post_end got=%0d/%0d/%b/%0d exp=3/3/1/3", state_o, wr_ptr_o, wrapped_o, trig_ptr_o);
    end
    rd(0, 3);
    rd(1, 3);
    rd(0, 2);
    repeat (4) step();
    total++;
    if (rq.size() != 0) begin bad++; $display("FAIL fp_read pending=%0d exp=0", rq.size()); rq.delete(); end
  endtask

  task automatic test_ignored();
    pb_words = 0;
    pb_mode = 0;
    pb_start = 1;
    step();
    pb_start = 0;
    repeat (3) step();
    total++;
    if ({state_o, pb_words} !== {3'd3, 32'd0}) begin
      bad++;
      $display("FAIL pb_mode0 got=%0d/%0d exp=3/0", state_o, pb_words);
    end
    arm = 1;
    pb_start = 1;
    pb_mode = 1;
    step();
    arm = 0;
    pb_start = 0;
    mwp = 0;
    total++;
    if ({state_o, wr_ptr_o, wrapped_o, trig_seen_o} !== {3'd1, 4'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL arm_wins got=%0d/%0d/%b/%b exp=1/0/0/0", state_o, wr_ptr_o, wrapped_o, trig_seen_o);
    end
    freeze_req = 1;
    step();
    freeze_req = 0;
    pb_start = 1;
    step();
    pb_start = 0;
    repeat (3) step();
    total++;
    if ({state_o, wr_ptr_o, pb_words} !== {3'd3, 4'd0, 32'd0}) begin
      bad++;
      $display("FAIL pb_empty got=%0d/%0d/%0d exp=3/0/0", state_o, wr_ptr_o, pb_words);
    end
  endtask

  task automatic test_loop();
    int n;
    do_arm();
    for (int k = 0; k < 3; k++) cap(DATA_W'(16'h500 + k), DATA_W'(16'h600 + k), 2'b11);
    freeze_req = 1;
    step();
    freeze_req = 0;
    total++;
    if ({state_o, wr_ptr_o, wrapped_o} !== {3'd3, 4'd3, 1'b0}) begin
      bad++;
      $display("FAIL loop_fill got=%0d/%0d/%b exp=3/3/0", state_o, wr_ptr_o, wrapped_o);
    end
    pb_words = 0;
    for (int i = 0; i < 10; i++) push_pb(i % 3);
    pb_mode = 2;
    pb_start = 1;
    step();
    pb_start = 0;
    pb_mode = 1;
    repeat (10) step();
    pb_stop = 1;
    step();
    pb_stop = 0;
    repeat (3) step();
    n = pb_words;
    total++;
    if (state_o !== 3'd3) begin bad++; $display("FAIL loop_stop_state got=%0d exp=3", state_o); end
    repeat (4) step();
    total++;
    if (pb_words != n || n != 10 || pb_valid !== '0 || pq.size() != 0) begin
      bad++;
      $display("FAIL loop_words got=%0d/%0d left=%0d exp=10/10/0", n, pb_words, pq.size());
      pq.delete();
    end
  endtask

  task automatic test_async_reset();
    do_arm();
    cap(16'h6a0, 16'h6b0, 2'b11);
    cap(16'h6a1, 16'h6b1, 2'b11);
    trig = 1;
    post_trig_cnt = 5;
    cap(16'h6a2, 16'h6b2, 2'b11);
    trig = 0;
    cap(16'h6a3, 16'h6b3, 2'b11);
    total++;
    if (state_o !== 3'd2) begin bad++; $display("FAIL ar_pre got=%0d exp=2", state_o); end
    #2 rst_hs = 0;
    #1;
    total++;
    if ({state_o, wr_ptr_o, trig_ptr_o, trig_seen_o, wrapped_o, rd_valid, pb_valid} !== '0) begin
      bad++;
      $display("FAIL ar_async got=%0d/%0d/%0d/%b/%b", state_o, wr_ptr_o, trig_ptr_o, trig_seen_o, wrapped_o);
    end
    rst_hs = 1;
    step();
    do_arm();
    for (int k = 0; k < 4; k++) cap(DATA_W'(16'h700 + k), DATA_W'(16'h780 + k), 2'b11);
    trig = 1;
    post_trig_cnt = 0;
    cap(16'h7aa, 16'h7bb, 2'b10);
    trig = 0;
    total++;
    if ({state_o, wr_ptr_o, trig_ptr_o, trig_seen_o, wrapped_o} !== {3'd3, 4'd5, 4'd4, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL ar_rearm got=%0d/%0d/%0d/%b/%b exp=3/5/4/1/0", state_o, wr_ptr_o, trig_ptr_o, trig_seen_o, wrapped_o);
    end
    rd(0, 4);
    rd(1, 4);
    rd(0, 0);
    repeat (4) step();
    total++;
    if (rq.size() != 0) begin bad++; $display("FAIL ar_read pending=%0d exp=0", rq.size()); rq.delete(); end
  endtask

  initial begin
    test_reset();
    test_trigger();
    test_wrap_playback();
    test_trig_freeze();
    test_full_post();
    test_ignored();
    test_loop();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fm_spy_buffer_mc.md
Name: fm_spy_buffer_mc

Overview:
Multi-channel, parametrised fast-monitoring spy buffer, the next generation of the per-block fast-monitoring capture path.
- Records N_CH data streams into circular RAMs and freezes on an external trigger after a programmable post-trigger window, or immediately on a software freeze.
- Supports random-access readout and looped or single-pass playback onto the monitored bus.
- Sits between the user-logic monitoring taps and the fast-monitoring control/readout layer.

Parameters:
N_CH, 4, number of captured channels
DATA_W, 64, data width per channel
ADDR_W, 10, buffer depth = 2**ADDR_W words per channel

Ports:
clk_hs  in  1  high-speed clock; the only clock in the block
rst_hs  in  1  asynchronous, active-low reset
ch_data  in  N_CH*DATA_W  captured data; channel i occupies bits [i*DATA_W +: DATA_W]
ch_valid  in  N_CH  per-channel valid, stored alongside the data
arm  in  1  pulse: start capture
trig  in  1  pulse: trigger event
freeze_req  in  1  pulse: immediate freeze
post_trig_cnt  in  ADDR_W  writes performed after the trigger write
pb_mode  in  2  0 none, 1 single pass, 2 loop, 3 treated as 1
pb_start  in  1  pulse: start playback
pb_stop  in  1  pulse: abort playback
rd_en  in  1  readout request
rd_ch_sel  in  $clog2(N_CH)  channel selected for readout
rd_addr  in  ADDR_W  absolute RAM address for readout
rd_data  out  DATA_W  readout data
rd_sample_valid  out  1  stored valid bit of the word read
rd_valid  out  1  rd_data and rd_sample_valid are valid this cycle
pb_data  out  N_CH*DATA_W  playback data
pb_valid  out  N_CH  playback valid (the stored valid bits)
state_o  out  3  0 IDLE, 1 CAPTURE, 2 POST_TRIG, 3 FROZEN, 4 PLAYBACK
wr_ptr_o  out  ADDR_W  next write address
trig_ptr_o  out  ADDR_W  address written in the trigger cycle
trig_seen_o  out  1  a trigger was captured in the current buffer
wrapped_o  out  1  the buffer has wrapped at least once since arm

Behaviour:
Reset (rst_hs=0, asynchronous):
- State goes to IDLE.
- All pointers, counters and flags are cleared; all outputs are 0.
- RAM contents are not cleared.

Storage:
- One RAM per channel, (DATA_W+1) bits wide, holding {ch_valid[i], ch_data[i]}.
- All channels share a single write pointer and are written every cycle while in CAPTURE or POST_TRIG, regardless of ch_valid.
- wr_ptr increments modulo 2**ADDR_W; wrapped is set when wr_ptr rolls over from all-ones to 0.

IDLE:
- arm -> CAPTURE; wr_ptr, wrapped and trig_seen are cleared.
- rd_en is honoured (returns stale RAM contents).

CAPTURE:
- Each cycle writes, then increments wr_ptr.
- trig -> write occurs; trig_ptr <= wr_ptr; trig_seen <= 1.
  - post_trig_cnt = 0 -> FROZEN.
  - Otherwise -> POST_TRIG with cnt <= min(post_trig_cnt, 2**ADDR_W-1).
- freeze_req -> FROZEN; no write occurs in that cycle.
- freeze_req takes priority over a simultaneous trig: trig_ptr and trig_seen still update, no write occurs.
- arm is ignored; rd_en is ignored (rd_valid stays 0).

POST_TRIG:
- Each cycle writes and decrements cnt; the write made with cnt=1 is the last one, then -> FROZEN.
- Exactly the capped post_trig_cnt writes follow the trigger write.
- freeze_req -> FROZEN immediately with no write.
- Further trig pulses are ignored.

FROZEN:
- Read latency is 2 cycles: rd_en at cycle t returns rd_data, rd_sample_valid and rd_valid=1 at t+2. Back-to-back reads are supported, one per cycle.
- arm -> CAPTURE (re-arm, same clearing as from IDLE).
- pb_start with pb_mode != 0 and a non-empty buffer -> PLAYBACK.
  - The buffer is empty when wr_ptr=0 and wrapped=0.
  - pb_start on an empty buffer, or with pb_mode=0, is ignored.
- arm and pb_start in the same cycle: arm wins.

PLAYBACK:
- Start address = wrapped ? wr_ptr : 0; length = wrapped ? 2**ADDR_W : wr_ptr.
- Read address advances one per cycle.
- pb_data and pb_valid are presented 2 cycles after each address is issued; pb_valid is 0 at all other times.
- Mode 1 or 3: after the last address -> FROZEN once the pipeline drains.
- Mode 2: wraps to the start address and repeats indefinitely.
- pb_stop -> FROZEN; no further addresses are issued; words already in the pipeline (at most 2) are still presented.
- pb_mode is sampled at pb_start; later changes are ignored until the next start.
- rd_en is ignored during playback.

Test Plan:
- ADDR_W=4, N_CH=2: arm, drive ch_data = cycle count for 5 cycles, then trig with post_trig_cnt=3 -> trig_ptr_o=5, FROZEN after 9 writes, wr_ptr_o=9, wrapped_o=0; read addr 5 on ch1 -> rd_valid exactly 2 cycles later with the data written in the trigger cycle.
- ADDR_W=4: arm, run 20 cycles, freeze_req -> wrapped_o=1, wr_ptr_o=4, no write in the freeze cycle; pb_mode=1 playback -> 16 pb_valid-gated words, oldest-first from address 4, then FROZEN.
- trig and freeze_req in the same cycle at wr_ptr=7 -> FROZEN, trig_seen_o=1, trig_ptr_o=7, wr_ptr_o stays 7.
- post_trig_cnt=15, ADDR_W=4 -> 15 writes after the trigger write; the trigger sample survives at trig_ptr_o.
- pb_mode=2 playback of a 3-word buffer for 10 cycles, then pb_stop -> words cycle 0,1,2,0,...; no new words 3 cycles after stop; state_o=3.
- Assert rst_hs low during POST_TRIG -> state_o=0 and all outputs 0 immediately (asynchronously); re-arm captures correctly.
